// File: rtl/instr_sequencer.sv
// instr_sequencer: hard-wired T0..T6 control sequencer; define SEQ_SINGLE_STEP_EN to add a step-gated mode
module instr_sequencer #(
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [7:0]  ctl_in,
    output logic [5:0]  ctl_out,
    output logic [13:0] alu_op,
    output logic        Read,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE, FAULT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic adv;
    logic [OPC_W-1:0] opc;
    logic is_3r, is_un, is_md;
    logic [13:0] op_oh;
    logic [15:0] ra_oh, rb_oh, rc_oh, rin_c;
    logic [7:0] cin_c;
`ifdef SEQ_SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif
    assign opc   = ir[31 -: OPC_W];
    assign is_3r = opc <= OPC_W'(8);
    assign is_un = opc == OPC_W'(17) || opc == OPC_W'(18);
    assign is_md = opc == OPC_W'(15) || opc == OPC_W'(16);
    assign op_oh = is_3r ? 14'h1000 >> opc :
                   opc == OPC_W'(17) ? 14'h0008 :
                   opc == OPC_W'(18) ? 14'h0004 :
                   opc == OPC_W'(15) ? 14'h0002 :
                   opc == OPC_W'(16) ? 14'h0001 : '0;
    assign ra_oh = 16'h1 << ir[26:23];
    assign rb_oh = 16'h1 << ir[22:19];
    assign rc_oh = 16'h1 << ir[18:15];
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = run ? T0 : IDLE;
            T0:      state_nx = T1;
            T1:      state_nx = mem_ready ? T2 : cnt == CW'(MEM_TIMEOUT - 1) ? FAULT : T1;
            T2:      state_nx = T3;
            T3:      state_nx = (is_3r || is_un || is_md) ? T4 : FAULT;
            T4:      state_nx = is_un ? DONE : T5;
            T5:      state_nx = is_md ? T6 : DONE;
            T6:      state_nx = DONE;
            DONE:    state_nx = run ? T0 : IDLE;
            default: state_nx = FAULT;
        endcase
        if (!adv) state_nx = state;
    end
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            cnt   <= '0;
            fault <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == T1 && state_nx == T1) ? cnt + CW'(adv) : '0;
            if (state_nx == FAULT && state != FAULT) fault <= state == T3 ? 2'd1 : 2'd2;
        end
    end
    // ctl_in bits: 7 HIin, 6 LOin, 5 PCin, 4 IRin, 3 Yin, 2 Zin, 1 MARin, 0 MDRin
    always_comb begin
        Rout    = '0;
        rin_c   = '0;
        cin_c   = '0;
        ctl_out = '0;
        alu_op  = '0;
        Read    = 1'b0;
        done    = 1'b0;
        case (state)
            T0: begin
                ctl_out[1] = 1'b1;
                cin_c[1]   = 1'b1;
                cin_c[2]   = 1'b1;
                alu_op[13] = 1'b1;
            end
            T1: begin
                ctl_out[2] = 1'b1;
                cin_c[5]   = cnt == '0;
                cin_c[0]   = 1'b1;
                Read       = 1'b1;
            end
            T2: begin
                ctl_out[0] = 1'b1;
                cin_c[4]   = 1'b1;
            end
            T3: begin
                Rout     = is_md ? ra_oh : (is_3r || is_un) ? rb_oh : '0;
                cin_c[3] = is_3r || is_md;
                cin_c[2] = is_un;
                alu_op   = is_un ? op_oh : '0;
            end
            T4: begin
                Rout       = is_un ? '0 : is_3r ? rc_oh : rb_oh;
                alu_op     = is_un ? '0 : op_oh;
                cin_c[2]   = !is_un;
                ctl_out[2] = is_un;
                rin_c      = is_un ? ra_oh : '0;
            end
            T5: begin
                ctl_out[2] = 1'b1;
                rin_c      = is_md ? '0 : ra_oh;
                cin_c[6]   = is_md;
            end
            T6: begin
                ctl_out[3] = 1'b1;
                cin_c[7]   = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end
    assign busy   = state != IDLE;
    assign Rin    = adv ? rin_c : '0;
    assign ctl_in = adv ? cin_c : '0;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized instruction streams checked against a per-cycle microstep table model
module tb_instr_sequencer;
    logic clock = 1'b0, clear = 1'b0, run = 1'b0, mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [15:0] Rin, Rout;
    logic [7:0] ctl_in;
    logic [5:0] ctl_out;
    logic [13:0] alu_op;
    logic Read, busy, done;
    logic [1:0] fault;
    int vectors = 0, miscompares = 0;

    typedef struct packed {
        logic [15:0] rin, rout;
        logic [7:0]  cin;
        logic [5:0]  cout;
        logic [13:0] alu;
        logic        rd, bsy, dn;
        logic [1:0]  flt;
    } vec_t;

    vec_t exp_q[$];
    bit   mr_q[$];

    instr_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout), .ctl_in(ctl_in), .ctl_out(ctl_out), .alu_op(alu_op),
        .Read(Read), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clock = ~clock;

    function automatic vec_t act();
        return {Rin, Rout, ctl_in, ctl_out, alu_op, Read, busy, done, fault};
    endfunction

    // Position of each mnemonic in {IncPC,ADD,...,DIV}; -1 means illegal
    function automatic int alu_pos(input logic [4:0] o);
        case (o)
            5'b00000: return 1;  5'b00001: return 2;  5'b00010: return 3;
            5'b00011: return 4;  5'b00100: return 5;  5'b00101: return 6;
            5'b00110: return 7;  5'b00111: return 8;  5'b01000: return 9;
            5'b10001: return 10; 5'b10010: return 11; 5'b01111: return 12;
            5'b10000: return 13; default:  return -1;
        endcase
    endfunction

    function automatic vec_t blank();
        vec_t b = '0;
        b.bsy = 1'b1;
        return b;
    endfunction

    function automatic void push(input vec_t v, input bit m);
        exp_q.push_back(v);
        mr_q.push_back(m);
    endfunction

    // d = cycles of mem_ready low in T1 before it rises; d >= 15 means it never does
    function automatic void build(input logic [31:0] i, input int d);
        vec_t v;
        int p = alu_pos(i[31:27]);
        logic [15:0] ra = 16'h1 << i[26:23], rb = 16'h1 << i[22:19], rc = 16'h1 << i[18:15];
        logic [13:0] ab;
        exp_q.delete();
        mr_q.delete();
        v = blank(); v.cout = 6'b000010; v.cin = 8'b0000_0110; v.alu = 14'h2000; push(v, 0);
        for (int k = 0; k <= d && k < 15; k++) begin
            v = blank(); v.cout = 6'b000100; v.rd = 1'b1;
            v.cin = (k == 0) ? 8'b0010_0001 : 8'b0000_0001;
            push(v, k == d);
        end
        if (d >= 15) begin
            v = blank(); v.flt = 2'd2; push(v, 0);
            return;
        end
        v = blank(); v.cout = 6'b000001; v.cin = 8'h10; push(v, 0);
        if (p < 0) begin
            push(blank(), 0);
            v = blank(); v.flt = 2'd1; push(v, 0);
            return;
        end
        ab = 14'h1 << (13 - p);
        if (p <= 9) begin
            v = blank(); v.rout = rb; v.cin = 8'h08; push(v, 0);
            v = blank(); v.rout = rc; v.alu = ab; v.cin = 8'h04; push(v, 0);
            v = blank(); v.cout = 6'b000100; v.rin = ra; push(v, 0);
        end else if (p <= 11) begin
            v = blank(); v.rout = rb; v.alu = ab; v.cin = 8'h04; push(v, 0);
            v = blank(); v.cout = 6'b000100; v.rin = ra; push(v, 0);
        end else begin
            v = blank(); v.rout = ra; v.cin = 8'h08; push(v, 0);
            v = blank(); v.rout = rb; v.alu = ab; v.cin = 8'h04; push(v, 0);
            v = blank(); v.cout = 6'b000100; v.cin = 8'h40; push(v, 0);
            v = blank(); v.cout = 6'b001000; v.cin = 8'h80; push(v, 0);
        end
        v = blank(); v.dn = 1'b1; push(v, 0);
    endfunction

    // Entered at a negedge with the DUT in IDLE or in DONE; upto < 0 runs the whole table
    task automatic run_seq(input logic [31:0] i, input int d, input bit keep, input string nm, input int upto);
        int n;
        build(i, d);
        n = (upto < 0) ? exp_q.size() : upto + 1;
        ir = i; run = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            vectors++;
            if (act() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL %s step %0d: got %h expected %h", nm, k, act(), exp_q[k]);
            end
            mem_ready = mr_q[k];
            if (exp_q[k].dn) run = keep;
        end
        if (upto < 0 && exp_q[exp_q.size()-1].dn && !keep) begin
            @(negedge clock);
            vectors++;
            if (act() !== vec_t'('0)) begin
                miscompares++;
                $display("FAIL %s idle-after-done: got %h expected 0", nm, act());
            end
        end
    endtask

    task automatic pulse_clear(input string nm);
        run = 1'b0; mem_ready = 1'b0;
        clear = 1'b0;
        #1;
        vectors++;
        if (act() !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL %s clear: got %h expected 0", nm, act());
        end
        clear = 1'b1;
        @(negedge clock);
    endtask

    function automatic logic [31:0] mk(input logic [4:0] o);
        return {o, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
    endfunction

    task automatic test_reset();
        #2;
        vectors++;
        if (act() !== vec_t'('0)) begin
            miscompares++;
            $display("FAIL reset: got %h expected 0", act());
        end
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_examples();
        run_seq(32'h112B0000, 0, 0, "and_r2_r5_r6", -1);
        run_seq(32'h79880000, 0, 0, "mul_r3_r1", -1);
        run_seq({5'b10000, 4'd0, 4'd15, 4'd9, 15'd0}, 2, 0, "div_r0_r15", -1);
        run_seq({5'b10001, 4'd15, 4'd0, 4'd3, 15'd0}, 14, 0, "neg_r15_r0", -1);
    endtask

    task automatic test_random();
        logic [4:0] ops[13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                 5'd15, 5'd16, 5'd17, 5'd18};
        for (int n = 0; n < 40; n++)
            run_seq(mk(ops[$urandom_range(0, 12)]), $urandom_range(0, 9),
                    1'($urandom_range(0, 1)), "random", -1);
    endtask

    task automatic test_back_to_back();
        run_seq(mk(5'b10010), $urandom_range(0, 3), 1, "not_first", -1);
        run_seq(mk(5'b10010), $urandom_range(0, 3), 0, "not_second", -1);
    endtask

    task automatic test_clear_mid();
        run_seq(32'h112B0000, 0, 0, "clear_mid_t4", 4);
        pulse_clear("clear_mid_t4");
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_mid_t4 stays_idle: busy %b expected 0", busy);
        end
    endtask

    task automatic hold_fault(input logic [1:0] f, input string nm);
        run = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            vectors++;
            if (fault !== f || busy !== 1'b1 || act() !== {blank()} + vec_t'(f)) begin
                miscompares++;
                $display("FAIL %s sticky: got %h fault %0d expected fault %0d", nm, act(), fault, f);
            end
        end
        pulse_clear(nm);
    endtask

    task automatic test_timeout();
        run_seq(mk(5'b00000), 15, 0, "timeout", -1);
        hold_fault(2'd2, "timeout");
    endtask

    task automatic test_illegal();
        run_seq(mk(5'b11111), $urandom_range(0, 5), 0, "illegal_11111", -1);
        hold_fault(2'd1, "illegal_11111");
        run_seq(mk(5'b01011), 0, 0, "illegal_01011", -1);
        pulse_clear("illegal_01011");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_examples();
        test_random();
        test_back_to_back();
        test_clear_mid();
        test_timeout();
        test_illegal();
        run_seq(32'h112B0000, 1, 0, "after_clear", -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
